// File: rtl/painterengine_gpu_pkg.sv
// Shared GPU DMA definitions: arbiter state encoding and reader error codes.
package painterengine_gpu_pkg;

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_RESET   = 2'd1;
  localparam logic [1:0] ARB_RUN     = 2'd2;
  localparam logic [1:0] ARB_RELEASE = 2'd3;

  localparam logic [2:0] ERR_OK           = 3'b000;
  localparam logic [2:0] ERR_ROUTER       = 3'b001;
  localparam logic [2:0] ERR_ADDRESS      = 3'b010;
  localparam logic [2:0] ERR_ADDR_TIMEOUT = 3'b011;
  localparam logic [2:0] ERR_DATA_TIMEOUT = 3'b100;
  localparam logic [2:0] ERR_PROTOCOL     = 3'b101;
  localparam logic [2:0] ERR_ABORTED      = 3'b110;

  function automatic logic [1:0] onehot4_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/painterengine_gpu_rr_arbiter4.sv
// Combinational 4-way round-robin pick: first set request at or after the pointer, wrapping 3->0.
module painterengine_gpu_rr_arbiter4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [3:0] grant_o,
  output logic       valid_o
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = ptr_i + 2'(k);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
    valid_o = |req_i;
  end

endmodule

// File: rtl/painterengine_gpu_dma_reader_arbiter.sv
// Round-robin sharing of the single routed GPU DMA reader between four read clients.
module painterengine_gpu_dma_reader_arbiter
  import painterengine_gpu_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 2,
  parameter bit          ABORT_ENABLE = 1'b1
) (
  input  logic           i_wire_clock,
  input  logic           i_wire_resetn,
  input  logic [3:0]     i_wire_req,
  input  logic [4*32-1:0] i_wire_address,
  input  logic [4*32-1:0] i_wire_length,
  output logic [3:0]     o_wire_grant,
  output logic [3:0]     o_wire_done,
  output logic [3:0]     o_wire_error,
  output logic [2:0]     o_wire_error_type,
  output logic           o_wire_busy,
  output logic           o_wire_reader_resetn,
  output logic [3:0]     o_wire_reader_router,
  output logic [4*32-1:0] o_wire_reader_address,
  output logic [4*32-1:0] o_wire_reader_length,
  input  logic           i_wire_reader_done,
  input  logic           i_wire_reader_error,
  input  logic [2:0]     i_wire_reader_error_type
);

  localparam int unsigned CW = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RESET_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [3:0]    grant_q, grant_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    rr_q, rr_d;
  logic          resetn_q, resetn_d;
  logic [3:0]    done_q, done_d;
  logic [3:0]    error_q, error_d;
  logic [2:0]    etype_q, etype_d;

  logic [3:0]    pick_grant;
  logic          pick_valid;
  logic [31:0]   pick_addr;
  logic [31:0]   pick_len;
  logic          req_granted;

  painterengine_gpu_rr_arbiter4 u_rr (
    .req_i   (i_wire_req),
    .ptr_i   (rr_q),
    .grant_o (pick_grant),
    .valid_o (pick_valid)
  );

  always_comb begin
    pick_addr = '0;
    pick_len  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (pick_grant[i]) begin
        pick_addr = i_wire_address[i*32 +: 32];
        pick_len  = i_wire_length[i*32 +: 32];
      end
    end
  end

  assign req_granted = |(i_wire_req & grant_q);

  // resetn_d defaults low, so the reader is only released while RUN is entered or held.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    resetn_d = 1'b0;
    done_d   = '0;
    error_d  = '0;
    etype_d  = etype_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          addr_d  = pick_addr;
          len_d   = pick_len;
          cnt_d   = '0;
          state_d = ARB_RESET;
        end
      end
      ARB_RESET: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = ARB_RUN;
          resetn_d = 1'b1;
        end
      end
      ARB_RUN: begin
        resetn_d = 1'b1;
        if (i_wire_reader_error) begin
          error_d  = grant_q;
          etype_d  = i_wire_reader_error_type;
          resetn_d = 1'b0;
          state_d  = ARB_RELEASE;
        end else if (i_wire_reader_done) begin
          done_d   = grant_q;
          resetn_d = 1'b0;
          state_d  = ARB_RELEASE;
        end else if (ABORT_ENABLE && !req_granted) begin
          error_d  = grant_q;
          etype_d  = ERR_ABORTED;
          resetn_d = 1'b0;
          state_d  = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        grant_d = '0;
        addr_d  = '0;
        len_d   = '0;
        rr_d    = onehot4_to_idx(grant_q) + 2'd1;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      rr_q     <= '0;
      resetn_q <= 1'b0;
      done_q   <= '0;
      error_q  <= '0;
      etype_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      resetn_q <= resetn_d;
      done_q   <= done_d;
      error_q  <= error_d;
      etype_q  <= etype_d;
    end
  end

  always_comb begin
    o_wire_reader_address = '0;
    o_wire_reader_length  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (grant_q[i]) begin
        o_wire_reader_address[i*32 +: 32] = addr_q;
        o_wire_reader_length[i*32 +: 32]  = len_q;
      end
    end
  end

  assign o_wire_grant         = grant_q;
  assign o_wire_reader_router = grant_q;
  assign o_wire_done          = done_q;
  assign o_wire_error         = error_q;
  assign o_wire_error_type    = etype_q;
  assign o_wire_busy          = (state_q != ARB_IDLE);
  assign o_wire_reader_resetn = resetn_q;

endmodule
